// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and the LSU.
// One transaction in flight; LSU priority with a starvation override for fetch; fetch flush on redirect.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_busy,
  input  logic                i_ls_req,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic                i_ls_wren,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_bmask,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_ls_busy,
  output logic                o_mem_req,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wren,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int BM_W   = DATA_W / 8;
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t              state;
  owner_t              owner;
  logic [CNT_W-1:0]    lat_cnt;
  logic [SCNT_W-1:0]   starve_cnt;
  logic                flush_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wren_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BM_W-1:0]     bmask_q;

  logic in_idle, fetch_wins, done, if_owns, ls_owns, if_cancel;

  always_comb begin
    in_idle    = (state == IDLE) && !i_rst;
    fetch_wins = i_if_req && (!i_ls_req || starve_cnt == SCNT_W'(STARVE_MAX));
    o_if_gnt   = in_idle && fetch_wins;
    o_ls_gnt   = in_idle && i_ls_req && !fetch_wins;

    if_owns    = (state != IDLE) && (owner == OWN_IF);
    ls_owns    = (state != IDLE) && (owner == OWN_LS);
    done       = (state == WAIT) && (lat_cnt == '0);
    // A flush arriving in the completion cycle itself must also drop the response.
    if_cancel  = flush_q || i_if_flush;

    o_if_rvalid = done && (owner == OWN_IF) && !if_cancel;
    o_ls_rvalid = done && (owner == OWN_LS);
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    o_ls_rdata  = (o_ls_rvalid && !wren_q) ? i_mem_rdata : '0;
    o_if_busy   = (i_if_req || if_owns) && !o_if_rvalid;
    o_ls_busy   = (i_ls_req || ls_owns) && !o_ls_rvalid;

    o_mem_req   = (state == ISSUE);
    o_mem_addr  = o_mem_req ? addr_q  : '0;
    o_mem_wren  = o_mem_req && wren_q;
    o_mem_wdata = o_mem_req ? wdata_q : '0;
    o_mem_bmask = o_mem_req ? bmask_q : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      flush_q    <= 1'b0;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      wdata_q    <= '0;
      bmask_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          flush_q <= 1'b0;
          if (o_ls_gnt) begin
            state   <= ISSUE;
            owner   <= OWN_LS;
            addr_q  <= i_ls_addr;
            wren_q  <= i_ls_wren;
            wdata_q <= i_ls_wdata;
            bmask_q <= i_ls_bmask;
            if (i_if_req && starve_cnt != SCNT_W'(STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (o_if_gnt) begin
            state      <= ISSUE;
            owner      <= OWN_IF;
            addr_q     <= i_if_addr;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            bmask_q    <= '1;
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          lat_cnt <= CNT_W'(MEM_LAT - 1);
          state   <= WAIT;
          if (owner == OWN_IF && i_if_flush) flush_q <= 1'b1;
        end
        WAIT: begin
          if (owner == OWN_IF && i_if_flush) flush_q <= 1'b1;
          if (lat_cnt == '0) begin
            state   <= IDLE;
            flush_q <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
